// File: rtl/ledger_tx_driver.sv
// Initiator side of the ledger transaction interface.
// Commands are buffered in a small FIFO and issued to the ledger core, which
// cannot stall. Responses come back a fixed number of cycles after issue. A
// shadow pipe pairs each response with the tag of the command that caused it.
// Issue is credit-limited, so the response FIFO always has room for every
// response still in flight.
// Stream handshakes: a beat transfers on a rising clk edge where valid and
// ready are both high. A producer holds valid and its payload steady until
// that edge. The s_*/m_* ledger ports carry no ready.
module ledger_tx_driver #(
    parameter int USER_WIDTH    = 10,
    parameter int BALANCE_WIDTH = 64,
    parameter int TAG_WIDTH     = 8,
    parameter int CMD_DEPTH     = 4,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [TAG_WIDTH-1:0]     cmd_tag,
    input  logic                     cmd_opcode,
    input  logic [USER_WIDTH-1:0]    cmd_user_a,
    input  logic [USER_WIDTH-1:0]    cmd_user_b,
    input  logic [BALANCE_WIDTH-1:0] cmd_amount_0,
    input  logic [BALANCE_WIDTH-1:0] cmd_amount_1,
    output logic                     s_valid,
    output logic                     s_opcode,
    output logic [USER_WIDTH-1:0]    s_user_a,
    output logic [USER_WIDTH-1:0]    s_user_b,
    output logic [BALANCE_WIDTH-1:0] s_amount_0,
    output logic [BALANCE_WIDTH-1:0] s_amount_1,
    input  logic                     m_valid,
    input  logic                     m_success,
    input  logic [USER_WIDTH-1:0]    m_user_a,
    input  logic [USER_WIDTH-1:0]    m_user_b,
    input  logic [BALANCE_WIDTH-1:0] m_bal_a_0,
    input  logic [BALANCE_WIDTH-1:0] m_bal_a_1,
    input  logic [BALANCE_WIDTH-1:0] m_bal_b_0,
    input  logic [BALANCE_WIDTH-1:0] m_bal_b_1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    output logic                     rsp_success,
    output logic [BALANCE_WIDTH-1:0] rsp_bal_a_0,
    output logic [BALANCE_WIDTH-1:0] rsp_bal_a_1,
    output logic [BALANCE_WIDTH-1:0] rsp_bal_b_0,
    output logic [BALANCE_WIDTH-1:0] rsp_bal_b_1,
    output logic [31:0]              cnt_issued,
    output logic [31:0]              cnt_success,
    output logic [31:0]              cnt_fail,
    output logic                     err_protocol
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam logic [CPW:0] CMD_FULL = (CPW+1)'(CMD_DEPTH);
    localparam logic [RPW:0] RSP_FULL = (RPW+1)'(RSP_DEPTH);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]     tag;
        logic                     opcode;
        logic [USER_WIDTH-1:0]    user_a;
        logic [USER_WIDTH-1:0]    user_b;
        logic [BALANCE_WIDTH-1:0] amount_0;
        logic [BALANCE_WIDTH-1:0] amount_1;
    } cmd_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]     tag;
        logic                     success;
        logic [BALANCE_WIDTH-1:0] bal_a_0;
        logic [BALANCE_WIDTH-1:0] bal_a_1;
        logic [BALANCE_WIDTH-1:0] bal_b_0;
        logic [BALANCE_WIDTH-1:0] bal_b_1;
    } rsp_t;

    // Command FIFO storage and control
    cmd_t           cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_ptr;
    logic [CPW-1:0] cmd_rd_ptr;
    logic [CPW:0]   cmd_count;
    logic           cmd_full;
    logic           cmd_empty;
    logic           cmd_push;
    logic           ready_en;
    cmd_t           cmd_in;
    cmd_t           cmd_head;

    // Response FIFO storage and control
    rsp_t           rsp_mem [RSP_DEPTH];
    logic [RPW-1:0] rsp_wr_ptr;
    logic [RPW-1:0] rsp_rd_ptr;
    logic [RPW:0]   rsp_count;
    logic           rsp_full;
    logic           rsp_push;
    logic           rsp_pop;
    rsp_t           rsp_in;
    rsp_t           rsp_out;

    // Issue, credit and shadow pipe
    logic [RPW:0]                credit;
    logic                        credit_free;
    logic                        issue;
    logic [2:0]                  sh_valid;
    logic [2:0][TAG_WIDTH-1:0]   sh_tag;
    logic [2:0][USER_WIDTH-1:0]  sh_user_a;
    logic [2:0][USER_WIDTH-1:0]  sh_user_b;
    logic                        proto_err;

    assign cmd_full  = (cmd_count == CMD_FULL);
    assign cmd_empty = (cmd_count == '0);
    assign cmd_ready = ready_en && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_in    = {cmd_tag, cmd_opcode, cmd_user_a, cmd_user_b, cmd_amount_0, cmd_amount_1};
    assign cmd_head  = cmd_mem[cmd_rd_ptr];

    assign rsp_full  = (rsp_count == RSP_FULL);
    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = m_valid && !rsp_full;
    assign rsp_in    = {sh_tag[2], m_success, m_bal_a_0, m_bal_a_1, m_bal_b_0, m_bal_b_1};
    // Data outputs read as zero whenever no response is presented
    assign rsp_out   = rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;

    assign rsp_tag     = rsp_out.tag;
    assign rsp_success = rsp_out.success;
    assign rsp_bal_a_0 = rsp_out.bal_a_0;
    assign rsp_bal_a_1 = rsp_out.bal_a_1;
    assign rsp_bal_b_0 = rsp_out.bal_b_0;
    assign rsp_bal_b_1 = rsp_out.bal_b_1;

    // A response leaving this cycle frees its slot at the same edge, so an
    // issue may reuse it; this keeps one issue per cycle with a full window.
    assign credit_free = rsp_pop && (credit != '0);
    assign issue       = enable && !cmd_empty && ((credit < RSP_FULL) || credit_free);

    assign proto_err = (m_valid != sh_valid[2])
                     || (m_valid && ((m_user_a != sh_user_a[2]) || (m_user_b != sh_user_b[2])))
                     || (m_valid && rsp_full);

    // Hold cmd_ready low through reset, open it one edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Command FIFO payload write
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= cmd_in;
    end

    // Command FIFO pointers and occupancy; the pop is the issue itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (issue)    cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            case ({cmd_push, issue})
                2'b10:   cmd_count <= cmd_count + 1'b1;
                2'b01:   cmd_count <= cmd_count - 1'b1;
                default: cmd_count <= cmd_count;
            endcase
        end
    end

    // Issue register toward the ledger; fields hold between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid    <= 1'b0;
            s_opcode   <= 1'b0;
            s_user_a   <= '0;
            s_user_b   <= '0;
            s_amount_0 <= '0;
            s_amount_1 <= '0;
        end else begin
            s_valid <= issue;
            if (issue) begin
                s_opcode   <= cmd_head.opcode;
                s_user_a   <= cmd_head.user_a;
                s_user_b   <= cmd_head.user_b;
                s_amount_0 <= cmd_head.amount_0;
                s_amount_1 <= cmd_head.amount_1;
            end
        end
    end

    // Shadow pipe: stage 0 lines up with s_valid, stage 2 with m_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid  <= '0;
            sh_tag    <= '0;
            sh_user_a <= '0;
            sh_user_b <= '0;
        end else begin
            sh_valid  <= {sh_valid[1:0], issue};
            sh_tag    <= {sh_tag[1:0], cmd_head.tag};
            sh_user_a <= {sh_user_a[1:0], cmd_head.user_a};
            sh_user_b <= {sh_user_b[1:0], cmd_head.user_b};
        end
    end

    // Response FIFO payload write
    always_ff @(posedge clk) begin
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_in;
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + 1'b1;
                2'b01:   rsp_count <= rsp_count - 1'b1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

    // Credit tracks in-flight plus queued responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            case ({issue, credit_free})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Statistics counters and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_issued   <= '0;
            cnt_success  <= '0;
            cnt_fail     <= '0;
            err_protocol <= 1'b0;
        end else begin
            if (issue) cnt_issued <= cnt_issued + 1'b1;
            if (m_valid && m_success)  cnt_success <= cnt_success + 1'b1;
            if (m_valid && !m_success) cnt_fail    <= cnt_fail + 1'b1;
            if (proto_err) err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ledger_tx_driver.sv
// Testbench for ledger_tx_driver: ledger core stub, reference ledger,
// expected-response queue and scenario tasks.
module tb_ledger_tx_driver;

    localparam int UW = 10;
    localparam int BW = 64;
    localparam int TW = 8;
    localparam int CD = 4;
    localparam int RD = 4;
    localparam int RW = TW + 1 + 4 * BW;
    localparam logic [BW-1:0] INIT_BAL = 64'd1000000;

    typedef struct packed {
        logic          ok;
        logic [BW-1:0] a0;
        logic [BW-1:0] a1;
        logic [BW-1:0] b0;
        logic [BW-1:0] b1;
    } lres_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable, cmd_valid, cmd_ready, cmd_opcode;
    logic [TW-1:0] cmd_tag;
    logic [UW-1:0] cmd_user_a, cmd_user_b;
    logic [BW-1:0] cmd_amount_0, cmd_amount_1;
    logic s_valid, s_opcode;
    logic [UW-1:0] s_user_a, s_user_b;
    logic [BW-1:0] s_amount_0, s_amount_1;
    logic m_valid, m_success;
    logic [UW-1:0] m_user_a, m_user_b;
    logic [BW-1:0] m_bal_a_0, m_bal_a_1, m_bal_b_0, m_bal_b_1;
    logic rsp_valid, rsp_ready, rsp_success;
    logic [TW-1:0] rsp_tag;
    logic [BW-1:0] rsp_bal_a_0, rsp_bal_a_1, rsp_bal_b_0, rsp_bal_b_1;
    logic [31:0] cnt_issued, cnt_success, cnt_fail;
    logic err_protocol;

    // Ledger core stub state
    logic l1_valid, l1_success, l2_valid, l2_success;
    logic [UW-1:0] l1_ua, l1_ub, l2_ua, l2_ub;
    logic [BW-1:0] l1_a0, l1_a1, l1_b0, l1_b1, l2_a0, l2_a1, l2_b0, l2_b1;
    logic [BW-1:0] core_bal0 [1024];
    logic [BW-1:0] core_bal1 [1024];
    lres_t lr;
    logic inj_valid;

    // Reference ledger and scoreboard state
    logic [BW-1:0] ref_bal0 [1024];
    logic [BW-1:0] ref_bal1 [1024];
    logic [RW-1:0] exp_q [$];
    int n_checks, n_pass;
    int n_sent, n_exp_ok, n_exp_fail;
    int sv_run, sv_max, rsp_seen;
    logic last_acc, rand_mode;

    always #5 clk = ~clk;

    ledger_tx_driver #(
        .USER_WIDTH(UW), .BALANCE_WIDTH(BW), .TAG_WIDTH(TW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag), .cmd_opcode(cmd_opcode),
        .cmd_user_a(cmd_user_a), .cmd_user_b(cmd_user_b),
        .cmd_amount_0(cmd_amount_0), .cmd_amount_1(cmd_amount_1),
        .s_valid(s_valid), .s_opcode(s_opcode), .s_user_a(s_user_a), .s_user_b(s_user_b),
        .s_amount_0(s_amount_0), .s_amount_1(s_amount_1),
        .m_valid(m_valid), .m_success(m_success), .m_user_a(m_user_a), .m_user_b(m_user_b),
        .m_bal_a_0(m_bal_a_0), .m_bal_a_1(m_bal_a_1), .m_bal_b_0(m_bal_b_0), .m_bal_b_1(m_bal_b_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_success(rsp_success),
        .rsp_bal_a_0(rsp_bal_a_0), .rsp_bal_a_1(rsp_bal_a_1),
        .rsp_bal_b_0(rsp_bal_b_0), .rsp_bal_b_1(rsp_bal_b_1),
        .cnt_issued(cnt_issued), .cnt_success(cnt_success), .cnt_fail(cnt_fail),
        .err_protocol(err_protocol)
    );

    // Ledger rules: transfer moves amt0/amt1 from A to B; swap moves amt0 of
    // asset 0 A->B and amt1 of asset 1 B->A; a self-transaction changes nothing.
    function automatic lres_t ledger_apply(input logic op, input logic same,
                                           input logic [BW-1:0] a0, a1, b0, b1, amt0, amt1);
        lres_t r;
        r.a0 = a0; r.a1 = a1; r.b0 = b0; r.b1 = b1;
        if (!op) r.ok = (a0 >= amt0) && (a1 >= amt1);
        else     r.ok = (a0 >= amt0) && (b1 >= amt1);
        if (r.ok && !same) begin
            r.a0 = a0 - amt0;
            r.b0 = b0 + amt0;
            if (!op) begin r.a1 = a1 - amt1; r.b1 = b1 + amt1; end
            else     begin r.b1 = b1 - amt1; r.a1 = a1 + amt1; end
        end
        return r;
    endfunction

    assign m_valid   = l2_valid | inj_valid;
    assign m_success = l2_success;
    assign m_user_a  = l2_ua;
    assign m_user_b  = l2_ub;
    assign m_bal_a_0 = l2_a0;
    assign m_bal_a_1 = l2_a1;
    assign m_bal_b_0 = l2_b0;
    assign m_bal_b_1 = l2_b1;

    // Ledger core stub: two-cycle fixed latency, shares rst_n with the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_valid <= 1'b0;
            l2_valid <= 1'b0;
            for (int u = 0; u < 1024; u++) begin
                core_bal0[u] = INIT_BAL;
                core_bal1[u] = INIT_BAL;
            end
        end else begin
            l2_valid <= l1_valid; l2_success <= l1_success;
            l2_ua <= l1_ua; l2_ub <= l1_ub;
            l2_a0 <= l1_a0; l2_a1 <= l1_a1; l2_b0 <= l1_b0; l2_b1 <= l1_b1;
            l1_valid <= s_valid;
            if (s_valid) begin
                lr = ledger_apply(s_opcode, s_user_a == s_user_b,
                                  core_bal0[s_user_a], core_bal1[s_user_a],
                                  core_bal0[s_user_b], core_bal1[s_user_b],
                                  s_amount_0, s_amount_1);
                core_bal0[s_user_a] = lr.a0; core_bal1[s_user_a] = lr.a1;
                core_bal0[s_user_b] = lr.b0; core_bal1[s_user_b] = lr.b1;
                l1_success <= lr.ok; l1_ua <= s_user_a; l1_ub <= s_user_b;
                l1_a0 <= lr.a0; l1_a1 <= lr.a1; l1_b0 <= lr.b0; l1_b1 <= lr.b1;
            end
        end
    end

    // One clock step; responses taken at the coming edge are scored here
    task automatic tick();
        logic [RW-1:0] got, e;
        @(negedge clk);
        if (s_valid) sv_run++; else sv_run = 0;
        if (sv_run > sv_max) sv_max = sv_run;
        if (rsp_valid) rsp_seen++;
        last_acc = cmd_valid && cmd_ready;
        if (rsp_valid && rsp_ready) begin
            got = {rsp_tag, rsp_success, rsp_bal_a_0, rsp_bal_a_1, rsp_bal_b_0, rsp_bal_b_1};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL rsp_data got=%h required=%h", got, e);
                else n_pass++;
            end
        end
        @(posedge clk);
        #1;
        if (rand_mode) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        for (int u = 0; u < 1024; u++) begin
            ref_bal0[u] = INIT_BAL;
            ref_bal1[u] = INIT_BAL;
        end
        n_sent = 0; n_exp_ok = 0; n_exp_fail = 0;
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0; rsp_ready = 1'b0; enable = 1'b1; inj_valid = 1'b0; rand_mode = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        reset_model();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one command until accepted, then record its expected response
    task automatic send_cmd(input logic [TW-1:0] tag, input logic op,
                            input logic [UW-1:0] ua, input logic [UW-1:0] ub,
                            input logic [BW-1:0] amt0, input logic [BW-1:0] amt1);
        logic acc;
        lres_t r;
        cmd_tag = tag; cmd_opcode = op; cmd_user_a = ua; cmd_user_b = ub;
        cmd_amount_0 = amt0; cmd_amount_1 = amt1; cmd_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            tick();
            acc = last_acc;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            $display("FAIL send_timeout tag=%0h accepted=0 required=1", tag);
        end else begin
            n_pass++;
            r = ledger_apply(op, ua == ub, ref_bal0[ua], ref_bal1[ua], ref_bal0[ub], ref_bal1[ub], amt0, amt1);
            ref_bal0[ua] = r.a0; ref_bal1[ua] = r.a1;
            ref_bal0[ub] = r.b0; ref_bal1[ub] = r.b1;
            exp_q.push_back({tag, r.ok, r.a0, r.a1, r.b0, r.b1});
            n_sent++;
            if (r.ok) n_exp_ok++; else n_exp_fail++;
        end
    endtask

    // Let everything complete, then confirm nothing is left outstanding
    task automatic drain();
        rand_mode = 1'b0; rsp_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        repeat (6) tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_left got=%0d required=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; rsp_ready = 1'b0; enable = 1'b1; inj_valid = 1'b0; rand_mode = 1'b0;
        cmd_tag = '0; cmd_opcode = 1'b0; cmd_user_a = '0; cmd_user_b = '0;
        cmd_amount_0 = '0; cmd_amount_1 = '0;
        sv_run = 0; sv_max = 0; rsp_seen = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        reset_model();
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, s_valid, rsp_valid, err_protocol} !== 4'b0)
            $display("FAIL reset_flags got=%b required=0000", {cmd_ready, s_valid, rsp_valid, err_protocol});
        else n_pass++;
        n_checks++;
        if ({cnt_issued, cnt_success, cnt_fail} !== 96'b0)
            $display("FAIL reset_counters got=%h required=0", {cnt_issued, cnt_success, cnt_fail});
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after got=%b required=1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        send_cmd(8'h11, 1'b0, 10'd1, 10'd2, 64'd100, 64'd0);
        tick();
        n_checks++;
        if ({s_valid, s_user_a, s_user_b, s_amount_0} !== {1'b1, 10'd1, 10'd2, 64'd100})
            $display("FAIL single_issue got=%b/%0d/%0d/%0d required=1/1/2/100", s_valid, s_user_a, s_user_b, s_amount_0);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({m_valid, rsp_valid} !== 2'b10)
            $display("FAIL single_m_cycle got=%b required=10", {m_valid, rsp_valid});
        else n_pass++;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_tag, rsp_success} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL single_rsp got=%b/%h/%b required=1/11/1", rsp_valid, rsp_tag, rsp_success);
        else n_pass++;
        n_checks++;
        if ({rsp_bal_a_0, rsp_bal_b_0} !== {64'd999900, 64'd1000100})
            $display("FAIL single_bal got=%0d/%0d required=999900/1000100", rsp_bal_a_0, rsp_bal_b_0);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rsp_ready = 1'b1;
        sv_max = 0;
        for (int i = 0; i < 8; i++)
            send_cmd(TW'(8'h20 + i), 1'($urandom_range(0, 1)), UW'($urandom_range(0, 7)),
                     UW'($urandom_range(0, 7)), BW'($urandom_range(0, 5000)), BW'($urandom_range(0, 5000)));
        drain();
        n_checks++;
        if (sv_max != 8) $display("FAIL b2b_run got=%0d required=8", sv_max);
        else n_pass++;
        n_checks++;
        if (cnt_issued !== 32'd8) $display("FAIL b2b_issued got=%0d required=8", cnt_issued);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send_cmd(TW'(8'h40 + i), 1'b0, UW'(i), UW'(i + 1), BW'(1000 * i), BW'(0));
        repeat (6) tick();
        n_checks++;
        if ({cnt_issued, s_valid, cmd_ready, rsp_valid} !== {32'd4, 1'b0, 1'b0, 1'b1})
            $display("FAIL bp_stall got=%0d/%b/%b/%b required=4/0/0/1", cnt_issued, s_valid, cmd_ready, rsp_valid);
        else n_pass++;
        drain();
        n_checks++;
        if ({cnt_issued, cnt_success, cnt_fail} !== {32'd8, 32'(n_exp_ok), 32'(n_exp_fail)})
            $display("FAIL bp_counts got=%0d/%0d/%0d required=8/%0d/%0d", cnt_issued, cnt_success, cnt_fail, n_exp_ok, n_exp_fail);
        else n_pass++;
    endtask

    task automatic test_insufficient();
        apply_reset();
        send_cmd(8'h55, 1'b0, 10'd5, 10'd6, 64'd2000000, 64'd0);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        n_checks++;
        if ({rsp_valid, rsp_tag, rsp_success} !== {1'b1, 8'h55, 1'b0})
            $display("FAIL insuff_rsp got=%b/%h/%b required=1/55/0", rsp_valid, rsp_tag, rsp_success);
        else n_pass++;
        n_checks++;
        if ({rsp_bal_a_0, rsp_bal_b_0, cnt_fail} !== {INIT_BAL, INIT_BAL, 32'd1})
            $display("FAIL insuff_bal got=%0d/%0d/%0d required=1000000/1000000/1", rsp_bal_a_0, rsp_bal_b_0, cnt_fail);
        else n_pass++;
        drain();
    endtask

    task automatic test_self();
        apply_reset();
        send_cmd(8'h33, 1'b1, 10'd3, 10'd3, 64'd500, 64'd700);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        n_checks++;
        if ({rsp_valid, rsp_tag, rsp_success, rsp_bal_a_0, rsp_bal_b_1} !== {1'b1, 8'h33, 1'b1, INIT_BAL, INIT_BAL})
            $display("FAIL self_rsp got=%b/%h/%b/%0d/%0d required=1/33/1/1000000/1000000",
                     rsp_valid, rsp_tag, rsp_success, rsp_bal_a_0, rsp_bal_b_1);
        else n_pass++;
        drain();
    endtask

    task automatic test_enable();
        apply_reset();
        enable = 1'b0; rsp_ready = 1'b1; sv_max = 0;
        send_cmd(8'h61, 1'b0, 10'd1, 10'd2, 64'd10, 64'd20);
        send_cmd(8'h62, 1'b1, 10'd2, 10'd1, 64'd30, 64'd40);
        repeat (4) tick();
        n_checks++;
        if (cnt_issued !== 32'd0 || sv_max != 0)
            $display("FAIL enable_hold got=%0d/%0d required=0/0", cnt_issued, sv_max);
        else n_pass++;
        drain();
        n_checks++;
        if (cnt_issued !== 32'd2) $display("FAIL enable_resume got=%0d required=2", cnt_issued);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send_cmd(TW'($urandom), 1'($urandom_range(0, 1)), UW'($urandom_range(0, 7)),
                     UW'($urandom_range(0, 7)), BW'($urandom_range(0, 600000)), BW'($urandom_range(0, 600000)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        n_checks++;
        if ({cnt_issued, cnt_success, cnt_fail} !== {32'(n_sent), 32'(n_exp_ok), 32'(n_exp_fail)})
            $display("FAIL random_counts got=%0d/%0d/%0d required=%0d/%0d/%0d",
                     cnt_issued, cnt_success, cnt_fail, n_sent, n_exp_ok, n_exp_fail);
        else n_pass++;
        n_checks++;
        if (err_protocol !== 1'b0) $display("FAIL random_err got=%b required=0", err_protocol);
        else n_pass++;
    endtask

    task automatic test_protocol_error();
        apply_reset();
        n_checks++;
        if (err_protocol !== 1'b0) $display("FAIL perr_initial got=%b required=0", err_protocol);
        else n_pass++;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (err_protocol !== 1'b1) $display("FAIL perr_sticky got=%b required=1", err_protocol);
        else n_pass++;
        apply_reset();
        n_checks++;
        if ({err_protocol, rsp_valid} !== 2'b00) $display("FAIL perr_cleared got=%b required=00", {err_protocol, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send_cmd(TW'(8'h70 + i), 1'b0, UW'(i), UW'(i + 4), BW'(100), BW'(100));
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_valid, cmd_ready, rsp_valid, err_protocol, s_user_b, s_amount_0} !== '0)
            $display("FAIL midrst_outputs got=%b%b%b%b/%0d/%0d required=0000/0/0",
                     s_valid, cmd_ready, rsp_valid, err_protocol, s_user_b, s_amount_0);
        else n_pass++;
        n_checks++;
        if ({cnt_issued, cnt_success, cnt_fail} !== 96'b0)
            $display("FAIL midrst_counters got=%h required=0", {cnt_issued, cnt_success, cnt_fail});
        else n_pass++;
        reset_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_seen = 0;
        repeat (10) tick();
        n_checks++;
        if (rsp_seen != 0) $display("FAIL midrst_stale_rsp got=%0d required=0", rsp_seen);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_insufficient();
        test_self();
        test_enable();
        test_random();
        test_protocol_error();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
